mdu_iter: RTL

Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the Mini-MIPS core.
- Replaces single-cycle combinational multiply/divide with a radix-2^UNROLL shift-add / restoring-divide engine.
- Uses a start/busy/done handshake so the core control unit can stall.
- Supports signed and unsigned MULT/DIV plus direct MTHI/MTLO writes.
- Sits beside the ALU; hi/lo feed the core's hi_out/lo_out.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_step.sv | 36 +++
 rtl/mdu_iter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } mdu_state_e;

  // Counter must hold XLEN/UNROLL itself, hence the +1.
  function automatic int mdu_cnt_w(input int xlen, input int unroll);
    return $clog2(xlen / unroll + 1);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply (LSB first) or restoring
// divide (MSB first) on an {hi, lo} scratch pair.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] m,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          ge;

  // Multiply: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole pair right one place.
  // Divide: shift the next dividend bit into the remainder and subtract the
  // divisor when it fits; the quotient bit enters lo from the bottom.
  always_comb begin
    sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, m} : '0);
    rem_sh = {hi_in, lo_in[XLEN-1]};
    ge     = (rem_sh >= {1'b0, m});
    diff   = rem_sh - {1'b0, m};
    hi_out = sum[XLEN:1];
    lo_out = {sum[0], lo_in[XLEN-1:1]};
    if (is_div) begin
      hi_out = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      lo_out = {lo_in[XLEN-2:0], ge};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO pair, with a
// start/busy/done handshake so the core can stall on it.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int UNROLL    = 1,
  parameter int SIGNED_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int NITER = XLEN / UNROLL;
  localparam int CNT_W = mdu_cnt_w(XLEN, UNROLL);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NITER);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc_hi, acc_lo, mag_m;
  logic             op_div, neg_q, neg_r, dbz;

  logic             is_md, is_mt, sgn_op, sa, sb;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]  q_fix, r_fix;

  logic [UNROLL:0][XLEN-1:0] ch_hi;
  logic [UNROLL:0][XLEN-1:0] ch_lo;

  // Operand decode: magnitudes and sign bits for the op being started.
  always_comb begin
    is_md  = (op[2] == 1'b0);
    is_mt  = (op == MDU_MTHI) || (op == MDU_MTLO);
    sgn_op = (SIGNED_EN != 0) && is_md && !op[0];
    sa     = sgn_op & a[XLEN-1];
    sb     = sgn_op & b[XLEN-1];
    mag_a  = sa ? -a : a;
    mag_b  = sb ? -b : b;
  end

  // Sign fixup applied to the raw magnitudes at the end of the run. With a
  // zero divisor the remainder scratch ends up holding |a|, so negating it
  // by sign(a) restores the original a for hi.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = neg_q ? -acc_lo : acc_lo;
    r_fix    = neg_r ? -acc_hi : acc_hi;
  end

  assign ch_hi[0] = acc_hi;
  assign ch_lo[0] = acc_lo;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    mdu_step #(.XLEN(XLEN)) u_step (
      .is_div (op_div),
      .m      (mag_m),
      .hi_in  (ch_hi[i]),
      .lo_in  (ch_lo[i]),
      .hi_out (ch_hi[i+1]),
      .lo_out (ch_lo[i+1])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs, decoded from the state register only.
  always_comb begin
    state_nxt   = state;
    busy        = (state == S_RUN) || (state == S_FIXUP);
    done        = (state == S_DONE);
    div_by_zero = (state == S_DONE) && dbz;
    case (state)
      S_IDLE: begin
        if (start && is_md)      state_nxt = S_RUN;
        else if (start && is_mt) state_nxt = S_DONE;
      end
      S_RUN: begin
        if (flush)               state_nxt = S_IDLE;
        else if (cnt == CNT_ONE) state_nxt = S_FIXUP;
      end
      S_FIXUP: state_nxt = flush ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, and commit HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag_m  <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && is_md) begin
            // op[1] selects divide: dividend feeds lo, divisor is the step operand.
            acc_hi <= '0;
            acc_lo <= op[1] ? mag_a : mag_b;
            mag_m  <= op[1] ? mag_b : mag_a;
            op_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dbz    <= op[1] && (b == '0);
            cnt    <= CNT_INIT;
          end else if (start && is_mt) begin
            dbz <= 1'b0;
            if (op[0]) lo <= a;
            else       hi <= a;
          end
        end
        S_RUN: begin
          if (!flush) begin
            acc_hi <= ch_hi[UNROLL];
            acc_lo <= ch_lo[UNROLL];
            cnt    <= cnt - CNT_ONE;
          end
        end
        S_FIXUP: begin
          if (!flush) begin
            if (op_div) begin
              hi <= r_fix;
              lo <= dbz ? '1 : q_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
